number_rom_arbiter: RTL and testbench

//  Time-shares the single numbers glyph ROM between score_controller and time_controller.

---
 rtl/snake_pkg.sv | 14 +
 rtl/number_rom_tag_pipe.sv | 40 ++++
 rtl/number_rom_arbiter.sv | 115 +++++++++++
 tb/tb_number_rom_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared definitions for the numbers glyph ROM sharing logic.
package snake_pkg;

    // Identifies which controller issued a ROM lookup
    typedef enum logic {
        REQ_SCORE = 1'b0,
        REQ_TIME  = 1'b1
    } req_owner_e;

    localparam int NUM_ROM_LATENCY = 1;
    localparam int DIGIT_W         = 4;
    localparam int NUM_ADDR_W      = 8;

endpackage

// File: rtl/number_rom_tag_pipe.sv
// Shift register carrying {valid, owner} alongside each ROM lookup so the
// returned pixel can be routed to whoever asked for it.
module number_rom_tag_pipe
    import snake_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clock_25,
    input  logic       reset,
    input  logic       flush,
    input  logic       in_valid,
    input  req_owner_e in_owner,
    output logic       out_valid,
    output req_owner_e out_owner
);

    logic [DEPTH-1:0] valid_q;
    req_owner_e       owner_q [DEPTH];

    // Shift tags one stage per cycle; a flush drops every lookup still in flight
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                owner_q[i] <= REQ_SCORE;
            end
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                valid_q[i] <= valid_q[i-1] && !flush;
                owner_q[i] <= owner_q[i-1];
            end
            valid_q[0] <= in_valid && !flush;
            owner_q[0] <= in_owner;
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_owner = owner_q[DEPTH-1];

endmodule

// File: rtl/number_rom_arbiter.sv
// Round-robin arbiter that time-shares the numbers glyph ROM between the
// score and time controllers, and routes each returned pixel to its owner.
module number_rom_arbiter #(
    parameter int ROM_LATENCY = snake_pkg::NUM_ROM_LATENCY,
    parameter int DIGIT_W     = snake_pkg::DIGIT_W,
    parameter int ADDR_W      = snake_pkg::NUM_ADDR_W
) (
    input  logic               clock_25,
    input  logic               reset,
    input  logic               sync_reset,
    input  logic               score_req,
    input  logic [DIGIT_W-1:0] score_digit,
    input  logic [ADDR_W-1:0]  score_addr,
    output logic               score_gnt,
    input  logic               time_req,
    input  logic [DIGIT_W-1:0] time_digit,
    input  logic [ADDR_W-1:0]  time_addr,
    output logic               time_gnt,
    output logic [DIGIT_W-1:0] selected_number,
    output logic [ADDR_W-1:0]  number_count,
    input  logic               number_pixel,
    output logic               score_pixel,
    output logic               score_pixel_valid,
    output logic               time_pixel,
    output logic               time_pixel_valid
);

    import snake_pkg::*;

    req_owner_e priority_ptr;
    req_owner_e grant_owner;
    logic       grant_any;
    logic       tag_valid;
    req_owner_e tag_owner;

    // Grant one requester per cycle; on contention the pointer side wins
    always_comb begin
        score_gnt = 1'b0;
        time_gnt  = 1'b0;
        if (reset && !sync_reset) begin
            if (score_req && time_req) begin
                score_gnt = (priority_ptr == REQ_SCORE);
                time_gnt  = (priority_ptr == REQ_TIME);
            end else begin
                score_gnt = score_req;
                time_gnt  = time_req;
            end
        end
    end

    assign grant_any   = score_gnt | time_gnt;
    assign grant_owner = time_gnt ? REQ_TIME : REQ_SCORE;

    // Register the granted lookup onto the ROM bus and hand priority to the loser
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            priority_ptr    <= REQ_SCORE;
            selected_number <= '0;
            number_count    <= '0;
        end else if (sync_reset) begin
            priority_ptr    <= REQ_SCORE;
            selected_number <= '0;
            number_count    <= '0;
        end else begin
            if (grant_any) begin
                priority_ptr <= (grant_owner == REQ_SCORE) ? REQ_TIME : REQ_SCORE;
            end
            if (score_gnt) begin
                selected_number <= score_digit;
                number_count    <= score_addr;
            end else if (time_gnt) begin
                selected_number <= time_digit;
                number_count    <= time_addr;
            end else begin
                selected_number <= '0;
                number_count    <= '0;
            end
        end
    end

    number_rom_tag_pipe #(
        .DEPTH (ROM_LATENCY + 1)
    ) u_tag_pipe (
        .clock_25  (clock_25),
        .reset     (reset),
        .flush     (sync_reset),
        .in_valid  (grant_any),
        .in_owner  (grant_owner),
        .out_valid (tag_valid),
        .out_owner (tag_owner)
    );

    // Capture returning ROM data into the owner's pixel register with a one-cycle strobe
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            score_pixel       <= 1'b0;
            score_pixel_valid <= 1'b0;
            time_pixel        <= 1'b0;
            time_pixel_valid  <= 1'b0;
        end else begin
            score_pixel_valid <= 1'b0;
            time_pixel_valid  <= 1'b0;
            if (tag_valid && !sync_reset) begin
                if (tag_owner == REQ_SCORE) begin
                    score_pixel       <= number_pixel;
                    score_pixel_valid <= 1'b1;
                end else begin
                    time_pixel        <= number_pixel;
                    time_pixel_valid  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_number_rom_arbiter.sv
// Bench for number_rom_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based model.
module tb_number_rom_arbiter;

    logic       clock_25 = 1'b0;
    logic       reset = 1'b0;
    logic       sync_reset = 1'b0;
    logic       score_req = 1'b0;
    logic [3:0] score_digit = '0;
    logic [7:0] score_addr = '0;
    logic       score_gnt;
    logic       time_req = 1'b0;
    logic [3:0] time_digit = '0;
    logic [7:0] time_addr = '0;
    logic       time_gnt;
    logic [3:0] selected_number;
    logic [7:0] number_count;
    logic       number_pixel = 1'b0;
    logic       score_pixel;
    logic       score_pixel_valid;
    logic       time_pixel;
    logic       time_pixel_valid;

    int vectors = 0;
    int miscompares = 0;
    bit rom_mode = 1'b0;

    number_rom_arbiter dut (
        .clock_25          (clock_25),
        .reset             (reset),
        .sync_reset        (sync_reset),
        .score_req         (score_req),
        .score_digit       (score_digit),
        .score_addr        (score_addr),
        .score_gnt         (score_gnt),
        .time_req          (time_req),
        .time_digit        (time_digit),
        .time_addr         (time_addr),
        .time_gnt          (time_gnt),
        .selected_number   (selected_number),
        .number_count      (number_count),
        .number_pixel      (number_pixel),
        .score_pixel       (score_pixel),
        .score_pixel_valid (score_pixel_valid),
        .time_pixel        (time_pixel),
        .time_pixel_valid  (time_pixel_valid)
    );

    // 25 MHz pixel clock
    always #20 clock_25 = ~clock_25;

    // Glyph ROM contents: parity of {digit,addr}, or "only digit 5 lit" for routing checks
    function automatic bit rom_fn(input logic [3:0] d, input logic [7:0] a);
        if (rom_mode) return (d == 4'd5);
        return ^{d, a};
    endfunction

    // Synchronous ROM, one cycle from address to data
    always @(posedge clock_25) number_pixel <= rom_fn(selected_number, number_count);

    task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic apply_stimulus(input bit rst_n, input bit sync,
                                  input bit sr, input logic [3:0] sd, input logic [7:0] sa,
                                  input bit tr, input logic [3:0] td, input logic [7:0] ta);
        @(posedge clock_25);
        #1;
        reset       = rst_n;
        sync_reset  = sync;
        score_req   = sr;
        score_digit = sd;
        score_addr  = sa;
        time_req    = tr;
        time_digit  = td;
        time_addr   = ta;
    endtask

    // Reference model: each granted lookup is queued with the cycle its strobe is due
    typedef struct {
        int due;
        bit owner;
        bit pix;
    } look_t;

    look_t      pend[$];
    look_t      e;
    int         cyc = 0;
    bit         m_ptr = 1'b0;
    logic [3:0] m_sel = '0;
    logic [7:0] m_cnt = '0;
    bit         m_sv = 1'b0;
    bit         m_tv = 1'b0;
    bit         m_sp = 1'b0;
    bit         m_tp = 1'b0;
    bit         exp_sg;
    bit         exp_tg;
    bit         own;

    // Compare DUT against the model mid-cycle, then advance the model one cycle
    always @(negedge clock_25) begin
        if (!reset) begin
            m_ptr = 1'b0;
            m_sel = '0;
            m_cnt = '0;
            m_sv  = 1'b0;
            m_tv  = 1'b0;
            m_sp  = 1'b0;
            m_tp  = 1'b0;
            pend.delete();
        end
        exp_sg = 1'b0;
        exp_tg = 1'b0;
        if (reset && !sync_reset) begin
            if (score_req && time_req) begin
                exp_sg = !m_ptr;
                exp_tg = m_ptr;
            end else begin
                exp_sg = score_req;
                exp_tg = time_req;
            end
        end
        check_output("score_gnt", 8'(score_gnt), 8'(exp_sg));
        check_output("time_gnt", 8'(time_gnt), 8'(exp_tg));
        check_output("selected_number", 8'(selected_number), 8'(m_sel));
        check_output("number_count", number_count, m_cnt);
        check_output("score_pixel_valid", 8'(score_pixel_valid), 8'(m_sv));
        check_output("time_pixel_valid", 8'(time_pixel_valid), 8'(m_tv));
        check_output("score_pixel", 8'(score_pixel), 8'(m_sp));
        check_output("time_pixel", 8'(time_pixel), 8'(m_tp));

        cyc++;
        if (reset) begin
            if (sync_reset) begin
                pend.delete();
                m_ptr = 1'b0;
                m_sel = '0;
                m_cnt = '0;
            end else if (exp_sg || exp_tg) begin
                own   = exp_tg;
                m_sel = own ? time_digit : score_digit;
                m_cnt = own ? time_addr : score_addr;
                pend.push_back('{cyc + 2, own, rom_fn(m_sel, m_cnt)});
                m_ptr = !own;
            end else begin
                m_sel = '0;
                m_cnt = '0;
            end
        end
        m_sv = 1'b0;
        m_tv = 1'b0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            e = pend.pop_front();
            if (e.owner) begin
                m_tv = 1'b1;
                m_tp = e.pix;
            end else begin
                m_sv = 1'b1;
                m_sp = e.pix;
            end
        end
    end

    // Directed scenarios followed by randomized traffic
    initial begin
        // Reset held with both requesters active: nothing may leak out
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b0, 1'b0, 1'b1, 4'd2, 8'd3, 1'b1, 4'd4, 8'd5);
            @(negedge clock_25);
            check_output("rst_score_gnt", 8'(score_gnt), 8'd0);
            check_output("rst_time_gnt", 8'(time_gnt), 8'd0);
            check_output("rst_bus", 8'(selected_number), 8'd0);
            check_output("rst_valids", 8'({score_pixel_valid, time_pixel_valid}), 8'd0);
        end
        apply_stimulus(1'b1, 1'b0, 1'b1, 4'd2, 8'd3, 1'b1, 4'd4, 8'd5);
        @(negedge clock_25);
        check_output("first_grant_score", 8'({score_gnt, time_gnt}), 8'b10);
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 8'd0);

        // Single score lookup of digit 7, pixel 45
        apply_stimulus(1'b1, 1'b0, 1'b1, 4'd7, 8'd45, 1'b0, 4'd0, 8'd0);
        @(negedge clock_25);
        check_output("single_gnt", 8'(score_gnt), 8'd1);
        apply_stimulus(1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 8'd0);
        @(negedge clock_25);
        check_output("single_digit", 8'(selected_number), 8'd7);
        check_output("single_addr", number_count, 8'd45);
        apply_stimulus(1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 8'd0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 8'd0);
        @(negedge clock_25);
        check_output("single_valid", 8'({score_pixel_valid, time_pixel_valid}), 8'b10);
        check_output("single_pixel", 8'(score_pixel), 8'd1);

        // Restart the pointer, then contention with routing ROM (only digit 5 lit)
        apply_stimulus(1'b1, 1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 8'd0);
        rom_mode = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i < 6) apply_stimulus(1'b1, 1'b0, 1'b1, 4'd3, 8'd10, 1'b1, 4'd5, 8'd20);
            else       apply_stimulus(1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 8'd0);
            @(negedge clock_25);
            if (i < 6) check_output("cont_gnt", 8'({score_gnt, time_gnt}), (i % 2 == 0) ? 8'b10 : 8'b01);
            if (i >= 3) begin
                check_output("cont_valid", 8'({score_pixel_valid, time_pixel_valid}),
                             ((i - 3) % 2 == 0) ? 8'b10 : 8'b01);
                if (score_pixel_valid) check_output("route_score_pix", 8'(score_pixel), 8'd0);
                if (time_pixel_valid)  check_output("route_time_pix", 8'(time_pixel), 8'd1);
            end
        end
        rom_mode = 1'b0;

        // Flush with two lookups in flight
        apply_stimulus(1'b1, 1'b0, 1'b1, 4'd1, 8'd2, 1'b1, 4'd9, 8'd3);
        @(negedge clock_25);
        check_output("flush_g1", 8'({score_gnt, time_gnt}), 8'b10);
        apply_stimulus(1'b1, 1'b0, 1'b1, 4'd1, 8'd2, 1'b1, 4'd9, 8'd3);
        @(negedge clock_25);
        check_output("flush_g2", 8'({score_gnt, time_gnt}), 8'b01);
        apply_stimulus(1'b1, 1'b1, 1'b1, 4'd1, 8'd2, 1'b1, 4'd9, 8'd3);
        @(negedge clock_25);
        check_output("flush_no_gnt", 8'({score_gnt, time_gnt}), 8'b00);
        apply_stimulus(1'b1, 1'b0, 1'b1, 4'd1, 8'd2, 1'b1, 4'd9, 8'd3);
        @(negedge clock_25);
        check_output("flush_ptr_score", 8'({score_gnt, time_gnt}), 8'b10);
        check_output("flush_bus_zero", 8'({selected_number, number_count[3:0]}), 8'd0);
        check_output("flush_valid_a", 8'({score_pixel_valid, time_pixel_valid}), 8'b00);

        // Long idle stretch
        for (int i = 0; i < 100; i++) begin
            apply_stimulus(1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 8'd0);
            @(negedge clock_25);
            if (i == 0) check_output("flush_valid_b", 8'({score_pixel_valid, time_pixel_valid}), 8'b00);
            if (i >= 4) begin
                check_output("idle_digit", 8'(selected_number), 8'd0);
                check_output("idle_addr", number_count, 8'd0);
                check_output("idle_valids", 8'({score_pixel_valid, time_pixel_valid}), 8'd0);
            end
        end

        // Randomized traffic with occasional restarts and resets
        for (int i = 0; i < 800; i++) begin
            apply_stimulus(1'($urandom_range(0, 59) != 0), 1'($urandom_range(0, 19) == 0),
                           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
        end
        for (int i = 0; i < 6; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 8'd0);
        @(negedge clock_25);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
